scroll_display: RTL

Parametrised multiplexed seven-segment scrolling controller. Holds a hex message of MSG_LEN nibbles and shows a NUM_DIGITS-wide window of it, stepping left or right at a programmable rate with pause and reload. It takes the place of the separate clock-divider, scroll and display-driver trio: the whole block runs on the 100 MHz board clock using internal tick enables, with no derived clocks.

---
 rtl/scroll_pkg.sv | 23 ++
 rtl/seg7_decode.sv | 11 +
 rtl/scroll_display.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling seven-segment controller.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    PAUSED = 2'd2
  } state_e;

  // Segment patterns {dp,g,f,e,d,c,b,a}, active-high; entry 15 listed first
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Counter width for a modulus, never below one bit
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment pattern (dp always off).
module seg7_decode
  import scroll_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_c_o
);

  assign seg_c_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/scroll_display.sv
// Multiplexed seven-segment scrolling controller on a single clock with tick enables.
// Optional `BLINK_EN flashes the digit enables while the scroll is paused.
module scroll_display
  import scroll_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned MSG_LEN    = 16,
  parameter int unsigned SCAN_DIV   = 131072,
  parameter int unsigned SCROLL_DIV = 33333333
) (
  input  logic                    clk100mhz,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*MSG_LEN-1:0]    msg_data,
  input  logic                    dir,
  input  logic                    pause,
  output logic [NUM_DIGITS-1:0]   pos,
  output logic [7:0]              seg,
  output logic                    wrap
);

  localparam int unsigned OFF_W  = clog2_min1(MSG_LEN);
  localparam int unsigned SUM_W  = OFF_W + 1;
  localparam int unsigned K_W    = clog2_min1(NUM_DIGITS);
  localparam int unsigned SCAN_W = clog2_min1(SCAN_DIV);
  localparam int unsigned SCRL_W = clog2_min1(SCROLL_DIV);

  state_e                  state_q, state_d;
  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    scan_upd_q;
  logic [SCRL_W-1:0]       scroll_cnt_q, scroll_cnt_d;
  logic [OFF_W-1:0]        offset_q, offset_d;
  logic                    wrap_q, wrap_d;
  logic [4*MSG_LEN-1:0]    msg_q, msg_d;
  logic [NUM_DIGITS-1:0]   pos_q, pos_d;
  logic [7:0]              seg_q, seg_d;

  logic                    scan_tick;
  logic                    scroll_run;
  logic                    scroll_tick;
  logic [SUM_W-1:0]        idx_sum;
  logic [OFF_W-1:0]        nib_idx;
  logic [3:0]              msg_nib [MSG_LEN];
  logic [3:0]              cur_nib;
  logic [7:0]              seg_dec;
  logic                    blank;

  // Message register viewed as nibbles, nibble 0 in the top bits
  for (genvar i = 0; i < MSG_LEN; i++) begin : g_nib
    assign msg_nib[i] = msg_q[4*(MSG_LEN-1-i) +: 4];
  end

  assign scan_tick   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign scroll_run  = (state_q == SCROLL) && !pause && !load;
  assign scroll_tick = scroll_run && (scroll_cnt_q == SCRL_W'(SCROLL_DIV - 1));

  // offset < MSG_LEN and k < MSG_LEN, so one conditional subtract is an exact modulo
  assign idx_sum = SUM_W'(offset_q) + SUM_W'(k_q);
  assign nib_idx = (idx_sum >= SUM_W'(MSG_LEN)) ? OFF_W'(idx_sum - SUM_W'(MSG_LEN))
                                                : OFF_W'(idx_sum);
  assign cur_nib = msg_nib[nib_idx];

  seg7_decode u_dec (
    .nibble_i (cur_nib),
    .seg_c_o  (seg_dec)
  );

`ifdef BLINK_EN
  logic [SCRL_W-1:0] blink_cnt_q, blink_cnt_d;

  assign blink_cnt_d = (blink_cnt_q == SCRL_W'(SCROLL_DIV - 1)) ? '0
                                                                : blink_cnt_q + SCRL_W'(1);
  assign blank       = (state_q == PAUSED) && (blink_cnt_q >= SCRL_W'(SCROLL_DIV / 2));

  always_ff @(posedge clk100mhz or posedge clr) begin
    if (clr) begin
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Next-state logic for FSM, counters, offset and registered display outputs
  always_comb begin
    state_d      = state_q;
    scan_cnt_d   = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
    k_d          = k_q;
    scroll_cnt_d = scroll_cnt_q;
    offset_d     = offset_q;
    wrap_d       = 1'b0;
    msg_d        = msg_q;
    pos_d        = pos_q;
    seg_d        = seg_q;

    if (scan_tick) begin
      k_d = (k_q == K_W'(NUM_DIGITS - 1)) ? '0 : k_q + K_W'(1);
    end

    if (load) begin
      state_d = pause ? PAUSED : SCROLL;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        SCROLL:  state_d = pause ? PAUSED : SCROLL;
        PAUSED:  state_d = pause ? PAUSED : SCROLL;
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      msg_d        = msg_data;
      offset_d     = '0;
      scroll_cnt_d = '0;
    end else if (scroll_run) begin
      scroll_cnt_d = scroll_tick ? '0 : scroll_cnt_q + SCRL_W'(1);
      if (scroll_tick) begin
        if (dir) begin
          offset_d = (offset_q == '0) ? OFF_W'(MSG_LEN - 1) : offset_q - OFF_W'(1);
          wrap_d   = (offset_q == '0);
        end else begin
          offset_d = (offset_q == OFF_W'(MSG_LEN - 1)) ? '0 : offset_q + OFF_W'(1);
          wrap_d   = (offset_q == OFF_W'(MSG_LEN - 1));
        end
      end
    end

    // Display refreshes on the cycle after k advances; IDLE is held blank
    if (state_q == IDLE) begin
      pos_d = '0;
      seg_d = SEG_BLANK;
    end else if (scan_upd_q) begin
      pos_d = blank ? '0 : (NUM_DIGITS'(1) << (K_W'(NUM_DIGITS - 1) - k_q));
      seg_d = seg_dec;
    end
  end

  always_ff @(posedge clk100mhz or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      scan_cnt_q   <= '0;
      k_q          <= '0;
      scan_upd_q   <= 1'b0;
      scroll_cnt_q <= '0;
      offset_q     <= '0;
      wrap_q       <= 1'b0;
      msg_q        <= '0;
      pos_q        <= '0;
      seg_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      scan_cnt_q   <= scan_cnt_d;
      k_q          <= k_d;
      scan_upd_q   <= scan_tick;
      scroll_cnt_q <= scroll_cnt_d;
      offset_q     <= offset_d;
      wrap_q       <= wrap_d;
      msg_q        <= msg_d;
      pos_q        <= pos_d;
      seg_q        <= seg_d;
    end
  end

  assign pos  = pos_q;
  assign seg  = seg_q;
  assign wrap = wrap_q;

endmodule
